coeff_bank_server: RTL and testbench

COEFF_BANK_SERVER -- requirements
Module: coeff_bank_server

---
 rtl/coeff_bank_server_pkg.sv | 23 ++
 rtl/coeff_bank_server_if.sv | 15 +
 rtl/coeff_bank_ram.sv | 31 +++
 rtl/coeff_bank_server.sv | 151 +++++++++++++++
 tb/tb_coeff_bank_server.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/coeff_bank_server_pkg.sv
// Shared constants, FSM state encoding and helpers for the coefficient bank server.
package coeff_bank_server_pkg;

    localparam int NUM_FILTERS = 8;
    localparam int NUM_TAPS    = 128;
    localparam int COEFF_W     = 18;
    localparam int ADDR_W      = 6;
    localparam int WORD_W      = 36;
    localparam int LOAD_LEN    = 1024;
    localparam int K_W         = $clog2(LOAD_LEN);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        PENDING = 2'd2,
        ERROR   = 2'd3
    } state_t;

    function automatic logic [31:0] sext_coeff(input logic [COEFF_W-1:0] c);
        return {{(32-COEFF_W){c[COEFF_W-1]}}, c};
    endfunction

endpackage

// File: rtl/coeff_bank_server_if.sv
// Coefficient load-stream interface between a loader (master) and the bank server (slave).
interface coeff_bank_server_if;
    import coeff_bank_server_pkg::*;

    // A word transfers on a rising clock edge where cfg_valid and cfg_ready are both high;
    // the master holds cfg_data/cfg_last stable while cfg_valid is high and not yet accepted.
    logic               cfg_valid;
    logic               cfg_ready;
    logic [COEFF_W-1:0] cfg_data;
    logic               cfg_last;

    modport master (output cfg_valid, output cfg_data, output cfg_last, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_data, input cfg_last, output cfg_ready);

endinterface

// File: rtl/coeff_bank_ram.sv
// One coefficient bank: N_BLOCKS x DEPTH words, single write port, all blocks read in parallel.
module coeff_bank_ram
    import coeff_bank_server_pkg::*;
#(
    parameter int N_BLOCKS = NUM_FILTERS,
    parameter int DEPTH    = NUM_TAPS / 2
) (
    input  logic                                   clock,
    input  logic                                   we,
    input  logic [$clog2(N_BLOCKS*DEPTH)-1:0]      waddr,
    input  logic [WORD_W-1:0]                      wdata,
    input  logic [$clog2(DEPTH)-1:0]               raddr,
    output logic [N_BLOCKS-1:0][WORD_W-1:0]        rdata
);

    localparam int A_W = $clog2(DEPTH);
    localparam int B_W = $clog2(N_BLOCKS);

    logic [WORD_W-1:0] mem [N_BLOCKS][DEPTH];

    // Upper write-address bits pick the block, lower bits the word inside it.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr[A_W +: B_W]][waddr[A_W-1:0]] <= wdata;
        end
        for (int b = 0; b < N_BLOCKS; b++) begin
            rdata[b] <= mem[b][raddr];
        end
    end

endmodule

// File: rtl/coeff_bank_server.sv
// Double-buffered coefficient store: loads fill the shadow bank, frame_sync swaps it in.
// Optional COEFF_CHECKSUM_EN adds the cfg_checksum output.
module coeff_bank_server #(
    parameter int NUM_FILTERS = coeff_bank_server_pkg::NUM_FILTERS,
    parameter int NUM_TAPS    = coeff_bank_server_pkg::NUM_TAPS
) (
    input  logic                                        clock,
    input  logic                                        reset,
    coeff_bank_server_if.slave                          cfg,
    input  logic                                        frame_sync,
    input  logic [coeff_bank_server_pkg::ADDR_W-1:0]    coeffaddress,
    output logic [coeff_bank_server_pkg::WORD_W-1:0]    coeff0,
    output logic [coeff_bank_server_pkg::WORD_W-1:0]    coeff1,
    output logic [coeff_bank_server_pkg::WORD_W-1:0]    coeff2,
    output logic [coeff_bank_server_pkg::WORD_W-1:0]    coeff3,
    output logic [coeff_bank_server_pkg::WORD_W-1:0]    coeff4,
    output logic [coeff_bank_server_pkg::WORD_W-1:0]    coeff5,
    output logic [coeff_bank_server_pkg::WORD_W-1:0]    coeff6,
    output logic [coeff_bank_server_pkg::WORD_W-1:0]    coeff7,
    output logic                                        bank_sel,
    output logic                                        bank_valid,
    output logic                                        load_pending,
    output logic                                        load_error,
    output coeff_bank_server_pkg::state_t               fsm_state
`ifdef COEFF_CHECKSUM_EN
    ,
    output logic [31:0]                                 cfg_checksum
`endif
);

    import coeff_bank_server_pkg::*;

    localparam int WORDS = NUM_TAPS / 2;

    state_t             state, state_nxt;
    logic [K_W-1:0]     k;
    logic [COEFF_W-1:0] even_q;
    logic               accept;
    logic               at_end;
    logic               rd_sel, rd_valid;
    logic               we0, we1;
    logic [WORD_W-1:0]  wdata;
    logic [NUM_FILTERS-1:0][WORD_W-1:0] q0, q1, coeff_word;

    assign at_end = (k == K_W'(LOAD_LEN - 1));
    assign accept = cfg.cfg_valid && cfg.cfg_ready;

    always_comb begin
        state_nxt     = state;
        cfg.cfg_ready = 1'b0;
        case (state)
            IDLE, LOAD: begin
                cfg.cfg_ready = 1'b1;
                if (cfg.cfg_valid) begin
                    // cfg_last must coincide exactly with the final word of the stream.
                    if (cfg.cfg_last != at_end) state_nxt = ERROR;
                    else if (cfg.cfg_last)      state_nxt = PENDING;
                    else                        state_nxt = LOAD;
                end
            end
            PENDING: if (frame_sync) state_nxt = IDLE;
            ERROR:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            k          <= '0;
            even_q     <= '0;
            bank_sel   <= 1'b0;
            bank_valid <= 1'b0;
            load_error <= 1'b0;
            rd_sel     <= 1'b0;
            rd_valid   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                k <= (state_nxt == LOAD) ? k + 1'b1 : '0;
                if (!k[0]) even_q <= cfg.cfg_data;
            end
            if (state_nxt == ERROR) load_error <= 1'b1;
            if (state == PENDING && frame_sync) begin
                bank_sel   <= ~bank_sel;
                bank_valid <= 1'b1;
            end
            // Output select follows the bank that was active when the address was sampled.
            rd_sel   <= bank_sel;
            rd_valid <= bank_valid;
        end
    end

    // Word address is {filter, tap[6:1]}, which is just k without its pair bit.
    assign wdata = {cfg.cfg_data, even_q};
    assign we0   = accept && k[0] &&  bank_sel;
    assign we1   = accept && k[0] && !bank_sel;

    coeff_bank_ram #(.N_BLOCKS(NUM_FILTERS), .DEPTH(WORDS)) u_bank0 (
        .clock (clock),
        .we    (we0),
        .waddr (k[K_W-1:1]),
        .wdata (wdata),
        .raddr (coeffaddress),
        .rdata (q0)
    );

    coeff_bank_ram #(.N_BLOCKS(NUM_FILTERS), .DEPTH(WORDS)) u_bank1 (
        .clock (clock),
        .we    (we1),
        .waddr (k[K_W-1:1]),
        .wdata (wdata),
        .raddr (coeffaddress),
        .rdata (q1)
    );

    always_comb begin
        coeff_word = '0;
        for (int f = 0; f < NUM_FILTERS; f++) begin
            if (rd_valid) coeff_word[f] = rd_sel ? q1[f] : q0[f];
        end
    end

    assign coeff0       = coeff_word[0];
    assign coeff1       = coeff_word[1];
    assign coeff2       = coeff_word[2];
    assign coeff3       = coeff_word[3];
    assign coeff4       = coeff_word[4];
    assign coeff5       = coeff_word[5];
    assign coeff6       = coeff_word[6];
    assign coeff7       = coeff_word[7];
    assign load_pending = (state == PENDING);
    assign fsm_state    = state;

`ifdef COEFF_CHECKSUM_EN
    logic [31:0] cksum;

    // The first word of a load restarts the sum; nothing else is accepted outside IDLE/LOAD.
    always_ff @(posedge clock) begin
        if (reset) begin
            cksum <= '0;
        end else if (accept) begin
            cksum <= (state == IDLE) ? sext_coeff(cfg.cfg_data)
                                     : cksum + sext_coeff(cfg.cfg_data);
        end
    end

    assign cfg_checksum = cksum;
`endif

endmodule

// File: tb/tb_coeff_bank_server.sv
// Randomized bench for coeff_bank_server against a tap-list reference model.
module tb_coeff_bank_server;
    import coeff_bank_server_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        frame_sync;
    logic [5:0]  coeffaddress;
    logic [35:0] coeff [8];
    logic        bank_sel, bank_valid, load_pending, load_error;
    state_t      fsm_state;
`ifdef COEFF_CHECKSUM_EN
    logic [31:0] cfg_checksum;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Reference model: flat tap lists in load order plus the bank status flags.
    logic [17:0] act_c [1024];
    logic [17:0] shd_c [1024];
    bit          m_valid, m_sel, m_pending, m_err;
    logic [31:0] m_cksum;
    logic [35:0] exp_q [$];

    coeff_bank_server_if cfg ();

    always #5 clock = ~clock;

    coeff_bank_server dut (
        .clock        (clock),
        .reset        (reset),
        .cfg          (cfg),
        .frame_sync   (frame_sync),
        .coeffaddress (coeffaddress),
        .coeff0       (coeff[0]),
        .coeff1       (coeff[1]),
        .coeff2       (coeff[2]),
        .coeff3       (coeff[3]),
        .coeff4       (coeff[4]),
        .coeff5       (coeff[5]),
        .coeff6       (coeff[6]),
        .coeff7       (coeff[7]),
        .bank_sel     (bank_sel),
        .bank_valid   (bank_valid),
        .load_pending (load_pending),
        .load_error   (load_error),
        .fsm_state    (fsm_state)
`ifdef COEFF_CHECKSUM_EN
        ,
        .cfg_checksum (cfg_checksum)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [35:0] exp_word(input int f, input int a);
        if (!m_valid) return '0;
        return {act_c[f*128 + 2*a + 1], act_c[f*128 + 2*a]};
    endfunction

    function automatic logic [17:0] gen(input int mode, input int k);
        case (mode)
            0:       return 18'(k);
            1:       return 18'($urandom);
            default: return '1;
        endcase
    endfunction

    task automatic check_status(input string tag);
        check({tag, ".bank_sel"},     64'(bank_sel),      64'(m_sel));
        check({tag, ".bank_valid"},   64'(bank_valid),    64'(m_valid));
        check({tag, ".load_pending"}, 64'(load_pending),  64'(m_pending));
        check({tag, ".load_error"},   64'(load_error),    64'(m_err));
        check({tag, ".cfg_ready"},    64'(cfg.cfg_ready), 64'(!m_pending));
`ifdef COEFF_CHECKSUM_EN
        check({tag, ".cksum"},        64'(cfg_checksum),  64'(m_cksum));
`endif
    endtask

    task automatic read_check(input int a, input string tag);
        coeffaddress = 6'(a);
        for (int f = 0; f < 8; f++) exp_q.push_back(exp_word(f, a));
        @(negedge clock);
        for (int f = 0; f < 8; f++) check(tag, 64'(coeff[f]), 64'(exp_q.pop_front()));
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        cfg.cfg_valid  = 1'b0;
        cfg.cfg_last   = 1'b0;
        cfg.cfg_data   = '0;
        frame_sync     = 1'b0;
        repeat (2) @(negedge clock);
        reset     = 1'b0;
        m_valid   = 0;
        m_sel     = 0;
        m_pending = 0;
        m_err     = 0;
        m_cksum   = '0;
    endtask

    // Streams n words with random idle gaps; last_at < 0 never raises cfg_last.
    task automatic send_load(input int mode, input int n, input int last_at);
        logic [17:0] c;
        logic        got;
        int          t;
        m_cksum = '0;
        for (int k = 0; k < n; k++) begin
            c        = gen(mode, k);
            shd_c[k] = c;
            m_cksum  = m_cksum + 32'($signed(c));
            if ($urandom_range(0, 3) == 0) begin
                cfg.cfg_valid = 1'b0;
                @(negedge clock);
            end
            cfg.cfg_valid = 1'b1;
            cfg.cfg_data  = c;
            cfg.cfg_last  = (k == last_at);
            t = 0;
            do begin
                got = cfg.cfg_ready;
                @(negedge clock);
                t++;
            end while (!got && t < 20);
            check("cfg_ready_accept", 64'(got), 64'(1));
        end
        cfg.cfg_valid = 1'b0;
        cfg.cfg_last  = 1'b0;
        if (last_at == 1023)               m_pending = 1;
        else if (last_at >= 0 || n == 1024) m_err    = 1;
    endtask

    task automatic check_error_cycle(input string tag);
        check({tag, ".ready_low"}, 64'(cfg.cfg_ready), 64'(0));
        check({tag, ".err_set"},   64'(load_error),    64'(1));
        check({tag, ".st_error"},  64'(fsm_state),     64'(ERROR));
        @(negedge clock);
        check({tag, ".ready_back"}, 64'(cfg.cfg_ready), 64'(1));
        check({tag, ".st_idle"},    64'(fsm_state),     64'(IDLE));
    endtask

    // frame_sync for one cycle with a read sampled in the same cycle.
    task automatic frame_pulse(input int a, input string tag);
        bit was_pending;
        was_pending   = m_pending;
        frame_sync    = 1'b1;
        coeffaddress  = 6'(a);
        cfg.cfg_valid = was_pending;
        cfg.cfg_data  = 18'($urandom);
        cfg.cfg_last  = 1'b0;
        for (int f = 0; f < 8; f++) exp_q.push_back(exp_word(f, a));
        @(negedge clock);
        frame_sync    = 1'b0;
        cfg.cfg_valid = 1'b0;
        for (int f = 0; f < 8; f++) check({tag, ".swap_cycle_rd"}, 64'(coeff[f]), 64'(exp_q.pop_front()));
        if (was_pending) begin
            m_sel     = !m_sel;
            m_valid   = 1;
            m_pending = 0;
            act_c     = shd_c;
        end
        check({tag, ".state"}, 64'(fsm_state), 64'(IDLE));
        check_status(tag);
        read_check(a, {tag, ".post_swap_rd"});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        coeffaddress = '0;
        @(negedge clock);
        do_reset();

        // Reset state: outputs gated off, nothing loaded.
        for (int f = 0; f < 8; f++) check("rst_coeff", 64'(coeff[f]), 64'(0));
        check("rst_state", 64'(fsm_state), 64'(IDLE));
        check_status("rst");
        for (int i = 0; i < 4; i++) read_check($urandom_range(0, 63), "rst_rd");

        // frame_sync with nothing pending must not swap.
        frame_pulse(3, "idle_sync");

        // Ramp load (value = k), then swap.
        send_load(0, 1024, 1023);
        check_status("ramp_loaded");
        frame_pulse(5, "ramp_swap");
        read_check(2, "ramp_a2");
        check("ramp_a2_coeff2", 64'(coeff[2]), 64'({18'd261, 18'd260}));
        read_check(5, "ramp_a5");
        check("ramp_a5_coeff2", 64'(coeff[2]), 64'({18'd267, 18'd266}));
        read_check(63, "ramp_a63");

        // Random load held pending for 50 cycles: old bank keeps serving.
        send_load(1, 1024, 1023);
        repeat (50) @(negedge clock);
        check_status("held");
        for (int i = 0; i < 4; i++) read_check($urandom_range(0, 63), "held_old_rd");
        frame_pulse($urandom_range(0, 63), "held_swap");
        for (int i = 0; i < 4; i++) read_check($urandom_range(0, 63), "held_new_rd");

        // Early cfg_last at k=500.
        send_load(1, 501, 500);
        check_error_cycle("early_last");
        check_status("early_last");
        for (int i = 0; i < 4; i++) read_check($urandom_range(0, 63), "early_last_rd");

        // Missing cfg_last on the final word.
        send_load(1, 1024, -1);
        check_error_cycle("no_last");
        check_status("no_last");
        read_check($urandom_range(0, 63), "no_last_rd");

        // Reset in the middle of a load, then a clean load.
        send_load(1, 300, -1);
        do_reset();
        check_status("midload_rst");
        read_check($urandom_range(0, 63), "midload_rst_rd");
        send_load(1, 1024, 1023);
        check_status("fresh_loaded");
        frame_pulse($urandom_range(0, 63), "fresh_swap");
        for (int i = 0; i < 4; i++) read_check($urandom_range(0, 63), "fresh_rd");

        // All-ones (-1) load.
        send_load(2, 1024, 1023);
        check_status("neg_loaded");
`ifdef COEFF_CHECKSUM_EN
        check("cksum_all_ones", 64'(cfg_checksum), 64'(32'hFFFFFC00));
`endif
        frame_pulse($urandom_range(0, 63), "neg_swap");
        read_check($urandom_range(0, 63), "neg_rd");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
